// File: rtl/pipe_stage_skid_if.sv
// rtl/pipe_stage_skid_if.sv - valid/ready stream bundle carrying control and payload between pipeline stages
interface pipe_stage_skid_if #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 8
);
    logic              valid;
    logic              ready;
    logic [CTRL_W-1:0] ctrl;
    logic [DATA_W-1:0] data;

    modport master (output valid, output ctrl, output data, input  ready);
    modport slave  (input  valid, input  ctrl, input  data, output ready);
endinterface

// File: rtl/pipe_stage_skid.sv
// rtl/pipe_stage_skid.sv - elastic pipeline register with 2-entry skid buffer and flush; stall counter under PIPE_STATS_EN
module pipe_stage_skid #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 8,
    parameter int STAT_W = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    pipe_stage_skid_if.slave       in_s,
    pipe_stage_skid_if.master      out_m
`ifdef PIPE_STATS_EN
    ,
    output logic [STAT_W-1:0]      stall_cnt
`endif
);

    typedef enum logic [1:0] {
        S_EMPTY = 2'b00,
        S_ONE   = 2'b01,
        S_BAD   = 2'b10,
        S_TWO   = 2'b11
    } state_e;

    if (STAT_W < 1) begin : g_bad_stat_w
        $error("pipe_stage_skid: STAT_W must be at least 1");
    end

    logic              main_valid_q, main_valid_d;
    logic [CTRL_W-1:0] main_ctrl_q,  main_ctrl_d;
    logic [DATA_W-1:0] main_data_q,  main_data_d;
    logic              skid_valid_q, skid_valid_d;
    logic [CTRL_W-1:0] skid_ctrl_q,  skid_ctrl_d;
    logic [DATA_W-1:0] skid_data_q,  skid_data_d;
    logic              in_ready_q,   in_ready_d;

    state_e state;
    logic   in_fire;
    logic   out_fire;

    // Occupancy lives entirely in the valid bits; the enum is just a view of them.
    always_comb begin
        state = S_BAD;
        case ({skid_valid_q, main_valid_q})
            2'b00:   state = S_EMPTY;
            2'b01:   state = S_ONE;
            2'b11:   state = S_TWO;
            default: state = S_BAD;
        endcase
    end

    assign in_fire  = in_s.valid & in_ready_q;
    assign out_fire = main_valid_q & out_m.ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            main_valid_q <= 1'b0;
            main_ctrl_q  <= '0;
            main_data_q  <= '0;
            skid_valid_q <= 1'b0;
            skid_ctrl_q  <= '0;
            skid_data_q  <= '0;
            in_ready_q   <= 1'b1;
        end else begin
            main_valid_q <= main_valid_d;
            main_ctrl_q  <= main_ctrl_d;
            main_data_q  <= main_data_d;
            skid_valid_q <= skid_valid_d;
            skid_ctrl_q  <= skid_ctrl_d;
            skid_data_q  <= skid_data_d;
            in_ready_q   <= in_ready_d;
        end
    end

    always_comb begin
        main_valid_d = main_valid_q;
        main_ctrl_d  = main_ctrl_q;
        main_data_d  = main_data_q;
        skid_valid_d = skid_valid_q;
        skid_ctrl_d  = skid_ctrl_q;
        skid_data_d  = skid_data_q;

        if (flush) begin
            // Bubble insertion: control is killed, payload is left as-is.
            main_valid_d = 1'b0;
            main_ctrl_d  = '0;
            skid_valid_d = 1'b0;
            skid_ctrl_d  = '0;
        end else begin
            case (state)
                S_EMPTY: begin
                    if (in_fire) begin
                        main_valid_d = 1'b1;
                        main_ctrl_d  = in_s.ctrl;
                        main_data_d  = in_s.data;
                    end
                end
                S_ONE: begin
                    if (in_fire && out_fire) begin
                        main_ctrl_d  = in_s.ctrl;
                        main_data_d  = in_s.data;
                    end else if (in_fire) begin
                        skid_valid_d = 1'b1;
                        skid_ctrl_d  = in_s.ctrl;
                        skid_data_d  = in_s.data;
                    end else if (out_fire) begin
                        main_valid_d = 1'b0;
                    end
                end
                S_TWO: begin
                    if (out_fire) begin
                        main_ctrl_d  = skid_ctrl_q;
                        main_data_d  = skid_data_q;
                        skid_valid_d = 1'b0;
                    end
                end
                default: begin
                    main_valid_d = 1'b0;
                    skid_valid_d = 1'b0;
                end
            endcase
        end

        in_ready_d = ~skid_valid_d;
    end

    assign in_s.ready  = in_ready_q;
    assign out_m.valid = main_valid_q;
    assign out_m.ctrl  = main_ctrl_q & {CTRL_W{main_valid_q}};
    assign out_m.data  = main_data_q;

`ifdef PIPE_STATS_EN
    logic [STAT_W-1:0] stall_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= '0;
        end else if (main_valid_q && !out_m.ready && !(&stall_cnt_q)) begin
            stall_cnt_q <= stall_cnt_q + 1'b1;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// tb/tb_pipe_stage_skid.sv - randomized and directed bench for pipe_stage_skid against a queue model
module tb_pipe_stage_skid;

    localparam int DATA_W = 32;
    localparam int CTRL_W = 8;
    localparam int STAT_W = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic flush = 1'b0;

    pipe_stage_skid_if #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) in_s ();
    pipe_stage_skid_if #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) out_s ();

`ifdef PIPE_STATS_EN
    logic [STAT_W-1:0] stall_cnt;
`endif

    pipe_stage_skid #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .STAT_W(STAT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .in_s  (in_s),
        .out_m (out_s)
`ifdef PIPE_STATS_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: the stage is a FIFO of capacity two; entry = {ctrl, data}.
    logic [CTRL_W+DATA_W-1:0] mq[$];
    int unsigned m_stall = 0;

    initial begin
        in_s.valid  = 1'b0;
        in_s.ctrl   = '0;
        in_s.data   = '0;
        out_s.ready = 1'b0;
    end

    task automatic drive(input logic r, input logic f, input logic v,
                         input logic [CTRL_W-1:0] c, input logic [DATA_W-1:0] d,
                         input logic ordy);
        bit ifire, ofire;
        reset       = r;
        flush       = f;
        in_s.valid  = v;
        in_s.ctrl   = c;
        in_s.data   = d;
        out_s.ready = ordy;
        ifire = v && (mq.size() < 2);
        ofire = ordy && (mq.size() > 0);
        if (r) m_stall = 0;
        else if (mq.size() > 0 && !ordy && m_stall < (1 << STAT_W) - 1) m_stall++;
        if (r || f) begin
            mq.delete();
        end else begin
            if (ofire) void'(mq.pop_front());
            if (ifire) mq.push_back({c, d});
        end
        @(negedge clk);
    endtask

    task automatic idle(input logic ordy);
        drive(1'b0, 1'b0, 1'b0, '0, '0, ordy);
    endtask

    task automatic test_reset();
        drive(1'b1, 1'b0, 1'b0, '0, '0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, '0, '0, 1'b0);
        n_tests++; if (out_s.valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", out_s.valid); end
        n_tests++; if (out_s.ctrl !== 8'h00) begin n_fail++; $display("FAIL reset_ctrl got %h want 00", out_s.ctrl); end
        n_tests++; if (out_s.data !== 32'h0) begin n_fail++; $display("FAIL reset_data got %h want 0", out_s.data); end
        n_tests++; if (in_s.ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", in_s.ready); end
    endtask

    task automatic test_single();
        drive(1'b0, 1'b0, 1'b1, 8'h05, 32'h11, 1'b1);
        n_tests++; if (out_s.valid !== 1'b1) begin n_fail++; $display("FAIL single_valid got %b want 1", out_s.valid); end
        n_tests++; if (out_s.data !== 32'h11) begin n_fail++; $display("FAIL single_data got %h want 11", out_s.data); end
        n_tests++; if (out_s.ctrl !== 8'h05) begin n_fail++; $display("FAIL single_ctrl got %h want 05", out_s.ctrl); end
        n_tests++; if (in_s.ready !== 1'b1) begin n_fail++; $display("FAIL single_in_ready got %b want 1", in_s.ready); end
        idle(1'b1);
        n_tests++; if (out_s.valid !== 1'b0 || out_s.ctrl !== 8'h00) begin
            n_fail++; $display("FAIL single_drain got v=%b c=%h want v=0 c=00", out_s.valid, out_s.ctrl);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 1; i <= 8; i++) begin
            drive(1'b0, 1'b0, 1'b1, 8'(i + 8'h40), 32'(i), 1'b1);
            n_tests++;
            if (out_s.valid !== 1'b1 || out_s.data !== 32'(i) || out_s.ctrl !== 8'(i + 8'h40) || in_s.ready !== 1'b1) begin
                n_fail++;
                $display("FAIL b2b_%0d got v=%b d=%h c=%h r=%b want v=1 d=%h c=%h r=1",
                         i, out_s.valid, out_s.data, out_s.ctrl, in_s.ready, 32'(i), 8'(i + 8'h40));
            end
        end
        idle(1'b1);
        n_tests++; if (out_s.valid !== 1'b0) begin n_fail++; $display("FAIL b2b_tail got %b want 0", out_s.valid); end
    endtask

    task automatic fill_two();
        drive(1'b0, 1'b0, 1'b1, 8'h0A, 32'hA, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 8'h0B, 32'hB, 1'b0);
    endtask

    task automatic test_backpressure();
        fill_two();
        n_tests++; if (in_s.ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready got %b want 0", in_s.ready); end
        n_tests++; if (out_s.data !== 32'hA) begin n_fail++; $display("FAIL bp_head got %h want a", out_s.data); end
        idle(1'b0);
        n_tests++; if (out_s.data !== 32'hA || out_s.valid !== 1'b1) begin
            n_fail++; $display("FAIL bp_hold got v=%b d=%h want v=1 d=a", out_s.valid, out_s.data);
        end
        idle(1'b1);
        n_tests++; if (out_s.data !== 32'hB || in_s.ready !== 1'b1) begin
            n_fail++; $display("FAIL bp_second got d=%h r=%b want d=b r=1", out_s.data, in_s.ready);
        end
        idle(1'b1);
        n_tests++; if (out_s.valid !== 1'b0) begin n_fail++; $display("FAIL bp_empty got %b want 0", out_s.valid); end
    endtask

    task automatic test_flush();
        fill_two();
        drive(1'b0, 1'b1, 1'b1, 8'h0C, 32'hC, 1'b0);
        n_tests++; if (out_s.valid !== 1'b0 || out_s.ctrl !== 8'h00 || in_s.ready !== 1'b1) begin
            n_fail++; $display("FAIL flush got v=%b c=%h r=%b want v=0 c=00 r=1", out_s.valid, out_s.ctrl, in_s.ready);
        end
        for (int i = 0; i < 3; i++) begin
            idle(1'b1);
            n_tests++; if (out_s.valid !== 1'b0) begin n_fail++; $display("FAIL flush_leak_%0d got v=%b d=%h want v=0", i, out_s.valid, out_s.data); end
        end
    endtask

    task automatic test_reset_mid();
        fill_two();
        drive(1'b1, 1'b0, 1'b0, '0, '0, 1'b0);
        n_tests++; if (out_s.valid !== 1'b0 || out_s.ctrl !== 8'h00 || out_s.data !== 32'h0 || in_s.ready !== 1'b1) begin
            n_fail++; $display("FAIL rst_mid got v=%b c=%h d=%h r=%b want 0/00/0/1", out_s.valid, out_s.ctrl, out_s.data, in_s.ready);
        end
        drive(1'b0, 1'b0, 1'b1, 8'h0D, 32'hD, 1'b1);
        n_tests++; if (out_s.valid !== 1'b1 || out_s.data !== 32'hD || out_s.ctrl !== 8'h0D) begin
            n_fail++; $display("FAIL rst_mid_d got v=%b d=%h c=%h want 1/d/0d", out_s.valid, out_s.data, out_s.ctrl);
        end
        idle(1'b1);
    endtask

    task automatic test_random();
        logic [CTRL_W+DATA_W-1:0] head;
        logic exp_v, exp_r;
        logic [CTRL_W-1:0] exp_c;
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 63) == 0), ($urandom_range(0, 31) == 0),
                  1'($urandom_range(0, 1)), CTRL_W'($urandom), DATA_W'($urandom),
                  ($urandom_range(0, 3) != 0));
            exp_v = (mq.size() != 0);
            exp_r = (mq.size() < 2);
            head  = exp_v ? mq[0] : '0;
            exp_c = head[CTRL_W+DATA_W-1:DATA_W];
            n_tests++;
            if (out_s.valid !== exp_v || in_s.ready !== exp_r || out_s.ctrl !== exp_c ||
                (exp_v && out_s.data !== head[DATA_W-1:0])) begin
                n_fail++;
                $display("FAIL rand_%0d got v=%b r=%b c=%h d=%h want v=%b r=%b c=%h d=%h",
                         i, out_s.valid, in_s.ready, out_s.ctrl, out_s.data, exp_v, exp_r, exp_c, head[DATA_W-1:0]);
            end
`ifdef PIPE_STATS_EN
            n_tests++;
            if (stall_cnt !== STAT_W'(m_stall)) begin
                n_fail++; $display("FAIL rand_stall_%0d got %0d want %0d", i, stall_cnt, m_stall);
            end
`endif
        end
    endtask

`ifdef PIPE_STATS_EN
    task automatic test_stats();
        drive(1'b1, 1'b0, 1'b0, '0, '0, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 8'h01, 32'h55, 1'b0);
        n_tests++; if (stall_cnt !== 4'd0) begin n_fail++; $display("FAIL stat_start got %0d want 0", stall_cnt); end
        for (int i = 0; i < 20; i++) idle(1'b0);
        n_tests++; if (stall_cnt !== 4'd15) begin n_fail++; $display("FAIL stat_sat got %0d want 15", stall_cnt); end
        drive(1'b0, 1'b1, 1'b0, '0, '0, 1'b0);
        n_tests++; if (stall_cnt !== 4'd15) begin n_fail++; $display("FAIL stat_flush got %0d want 15", stall_cnt); end
        drive(1'b1, 1'b0, 1'b0, '0, '0, 1'b0);
        n_tests++; if (stall_cnt !== 4'd0) begin n_fail++; $display("FAIL stat_reset got %0d want 0", stall_cnt); end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_flush();
        test_reset_mid();
        test_random();
`ifdef PIPE_STATS_EN
        test_stats();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
- Parametrised, elastic successor to the fixed inter-stage pipeline registers (EX/MEM style).
- Carries a generic payload plus a control bundle between two pipeline stages.
- Uses a valid/ready handshake and a 2-entry skid buffer, so backpressure does not create a combinational ready path.
- Adds a synchronous flush that kills in-flight control bits (bubble insertion); one instance per stage boundary.

Parameters:
- DATA_W, 32: payload width (ALU result, store data, branch target...); never cleared by flush.
- CTRL_W, 8: control bundle width (RegWrite, MemRead, MemWrite...); forced to zero on flush or bubble.
- STAT_W, 16: width of stall counter (optional feature only).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- flush  in  1  synchronous kill of all held entries.
- in_valid  in  1  upstream entry valid.
- in_ready  out  1  stage can accept; registered.
- in_ctrl  in  CTRL_W  upstream control bundle.
- in_data  in  DATA_W  upstream payload.
- out_valid  out  1  head entry valid.
- out_ready  in  1  downstream accepts.
- out_ctrl  out  CTRL_W  head control; zero whenever out_valid=0.
- out_data  out  DATA_W  head payload.
- stall_cnt  out  STAT_W  present only with PIPE_STATS_EN.

Behaviour:
- Storage: main register (head) and skid register, each with data, ctrl and valid.
- State is encoded by the valid bits:
  - EMPTY: no valid entries.
  - ONE: main valid, skid empty.
  - TWO: main and skid valid.
- Fire conditions: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- in_ready = !skid_valid, driven from a flop. It is never derived combinationally from out_ready.
- Transitions, evaluated in priority order each rising edge:
  - reset: all valids=0, out_ctrl=0, out_data=0, in_ready=1, stall_cnt=0. State -> EMPTY.
  - flush (and not reset): all valids=0, ctrl regs=0, in_ready=1. A simultaneous in_fire is dropped. Data regs keep their value. State -> EMPTY.
  - EMPTY & in_fire: load main. State -> ONE.
  - ONE & in_fire & out_fire: main <= input. Stays ONE.
  - ONE & in_fire & !out_fire: input goes to skid; in_ready=0. State -> TWO.
  - ONE & !in_fire & out_fire: State -> EMPTY.
  - TWO & out_fire: main <= skid; skid cleared; in_ready=1. State -> ONE. in_fire is impossible here because in_ready=0.
  - Any state with no fire: hold all registers.
- Latency: 1 cycle from in_fire in EMPTY to out_valid=1.
- Throughput: 1 entry/cycle sustained while out_ready=1.
- Ordering is strictly FIFO, and no entry is ever duplicated or lost except by flush/reset.
- out_ctrl gating: out_ctrl = main_ctrl & {CTRL_W{main_valid}}, so invalid cycles present all-zero control (bubble).
- out_data must be stable while out_valid=1 & out_ready=0.
- Reset mid-transfer: all entries discarded; in_ready=1 on the cycle after reset deasserts.

Optional Feature:
- Macro PIPE_STATS_EN.
- When defined:
  - stall_cnt increments each cycle that out_valid=1 & out_ready=0.
  - It saturates at 2^STAT_W-1 and never wraps.
  - It is cleared by reset only; flush does not clear it.
- When undefined:
  - The stall_cnt port and counter logic are absent.
  - All other behaviour is identical.

Test Plan:
- Reset, then in_valid=1 with data=0x11, ctrl=0x05 and out_ready=1 -> next cycle out_valid=1, out_data=0x11, out_ctrl=0x05; in_ready stays 1.
- Stream 0x1..0x8 back-to-back with out_ready=1 -> outputs 0x1..0x8 in order, one per cycle, 1-cycle latency, no gaps.
- Send 0xA, 0xB with out_ready=0 -> state TWO, in_ready=0 and out_data=0xA held. Raise out_ready -> 0xA then 0xB emitted, in_ready=1 after the first out_fire.
- In state TWO, assert flush together with in_valid=1, data=0xC -> next cycle out_valid=0, out_ctrl=0, in_ready=1; 0xA, 0xB and 0xC are never emitted.
- Assert reset while in TWO -> next cycle out_valid=0, out_ctrl=0, out_data=0, in_ready=1; a subsequent 0xD passes with 1-cycle latency.
- PIPE_STATS_EN with STAT_W=4: hold out_valid=1 and out_ready=0 for 20 cycles -> stall_cnt reads 15 and holds. Flush -> still 15. Reset -> 0.
